pixel_plot_buffer: RTL

PIXEL_PLOT_BUFFER -- requirements
Module: pixel_plot_buffer

---
 rtl/pixel_plot_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pixel_plot_buffer.sv
// Decoupling buffer between a pixel drawing engine and a framebuffer write port.
// Computes linear addresses, drops off-screen plots, and queues writes in a small FIFO.
module pixel_plot_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  plot_x,
   input  logic [6:0]  plot_y,
   input  logic [2:0]  plot_colour,
   input  logic        plot_valid,
   output logic        plot_ready,
   output logic [14:0] fb_addr,
   output logic [2:0]  fb_data,
   output logic        fb_we,
   input  logic        fb_ack,
   output logic [7:0]  drop_count,
   output logic        busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SCREEN_W = 160;

   typedef struct packed {
      logic [14:0] addr;
      logic [2:0]  colour;
   } entry_t;

   typedef enum logic {
      ST_IDLE,
      ST_WRITE
   } state_t;

   entry_t            mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [7:0]        drop_q, drop_d;
   state_t            state_q;
   logic              fb_we_q;
   logic [14:0]       fb_addr_q;
   logic [2:0]        fb_data_q;

   logic              fifo_empty;
   logic              in_range;
   logic              accept;
   logic              enq;
   logic              deq;
   logic [14:0]       pixel_addr;
   entry_t            head;

   assign fifo_empty = (count_q == '0);
   assign plot_ready = (count_q < CNT_W'(DEPTH));
   assign in_range   = (plot_x <= 8'd159) && (plot_y <= 7'd119);
   assign accept     = plot_valid && plot_ready;
   assign enq        = accept && in_range;
   // A write slot frees up either when idle or when the framebuffer takes the current word.
   assign deq        = !fifo_empty && ((state_q == ST_IDLE) || fb_ack);
   assign pixel_addr = 15'(plot_y) * 15'(SCREEN_W) + 15'(plot_x);
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      count_d = count_q;
      drop_d  = drop_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (accept && !in_range && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // NOTE: storage has no reset; the occupancy count alone defines which words are meaningful.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[wr_ptr_q] <= '{addr: pixel_addr, colour: plot_colour};
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         drop_q    <= '0;
         state_q   <= ST_IDLE;
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
      end else begin
         count_q <= count_d;
         drop_q  <= drop_d;
         if (enq) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (deq) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (deq) begin
                  fb_addr_q <= head.addr;
                  fb_data_q <= head.colour;
                  fb_we_q   <= 1'b1;
                  state_q   <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (fb_ack) begin
                  if (deq) begin
                     fb_addr_q <= head.addr;
                     fb_data_q <= head.colour;
                  end else begin
                     fb_we_q <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               fb_we_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign fb_we      = fb_we_q;
   assign fb_addr    = fb_addr_q;
   assign fb_data    = fb_data_q;
   assign drop_count = drop_q;
   assign busy       = !fifo_empty || (state_q == ST_WRITE);

endmodule
